hilo_unit: RTL and testbench
============================

# hilo_unit

Owner of the architectural HI/LO register pair and the multi-cycle iterative divider behind it. It receives pipeline HI/LO write-backs (mult/multu results, mthi/mtlo) and executes div/divu in the background over WIDTH cycles, stalling the pipeline meanwhile. It serves forwarded HI/LO values back to the ALU's `hi_in`/`lo_in` for mfhi/mflo. It sits beside the EX stage and is written from the WB side.

## Interface
- WIDTH, 32, data width of HI, LO and divider operands

- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- wb_we_hi  in  1  write HI from write-back
- wb_we_lo  in  1  write LO from write-back
- wb_hi  in  WIDTH  HI write data
- wb_lo  in  WIDTH  LO write data
- div_start  in  1  start division; sampled only in IDLE
- div_signed  in  1  1 = div (two's complement), 0 = divu
- div_a  in  WIDTH  dividend
- div_b  in  WIDTH  divisor
- div_annul  in  1  cancel the in-flight division (exception/flush)
- stall_req  out  1  hold the pipeline
- div_busy  out  1  state is BUSY
- div_done  out  1  one-cycle pulse; result committed at this edge
- div_by_zero  out  1  one-cycle pulse with div_done when div_b was 0
- hi_rd  out  WIDTH  forwarded HI to ALU
- lo_rd  out  WIDTH  forwarded LO to ALU

## Operation
- States: IDLE, BUSY, DONE.
- IDLE, div_start=1, div_b≠0: latch sign_q = signed & (a[MSB]^b[MSB]) and sign_r = signed & a[MSB]. Latch |a| and |b| (raw values when unsigned). Clear the remainder accumulator and cnt=0. Go to BUSY.
- IDLE, div_start=1, div_b=0: go to DONE with q=all ones and r=div_a. Flag div_by_zero.
- BUSY: one restoring step per cycle.
  - Shift {rem, quo} left by 1 and trial-subtract the divisor from rem (WIDTH+1-bit subtract).
  - On non-negative result keep it and set quo[0]=1.
  - cnt increments. After the step with cnt=WIDTH-1, go to DONE.
- DONE: result is LO = sign_q ? −quo : quo and HI = sign_r ? −rem : rem.
  - Commit to HI/LO at this edge. Pulse div_done, return to IDLE.
- Signed −2^(W−1) / −1: LO=0x80000000, HI=0. This falls out of the magnitude path; no special case is required.
- div_start while BUSY/DONE: ignored.
- div_annul in BUSY or DONE: return to IDLE next edge. No HI/LO write, no div_done. div_annul in IDLE: no effect.
- HI/LO write priority at one edge: DONE result > wb write. HI and LO are resolved independently for wb writes.
- Forwarding (combinational):
  - hi_rd = DONE&!annul ? div HI : wb_we_hi ? wb_hi : HI_reg.
  - lo_rd is the same with LO.
- stall_req = (IDLE & div_start) | BUSY. Low in DONE.

## Timing
- Reset:
  - HI_reg = LO_reg = 0 and state=IDLE.
  - stall_req, div_busy, div_done and div_by_zero all 0.
  - hi_rd = lo_rd = 0 unless a wb write is concurrent.
  - rst mid-division aborts it; nothing is committed.
- Latency, div_b≠0: start sampled at edge 0; BUSY covers cycles 1..WIDTH; DONE is cycle WIDTH+1.
  - HI/LO are updated at the end of cycle WIDTH+1.
  - stall_req is high for cycles 0..WIDTH, i.e. WIDTH+1 cycles.
- Latency, div_b=0: DONE in cycle 1. stall_req is high in cycle 0 only.
- div_done and div_by_zero are high exactly during the DONE cycle.
- wb writes take effect at the next edge. Forwarding makes them visible to hi_rd/lo_rd in the same cycle.

## Test plan
- Reset, then read: hi_rd=lo_rd=0 and stall_req=0. Then wb_we_hi=1 with wb_hi=0x12345678: hi_rd=0x12345678 in the same cycle and HI_reg holds it afterwards. LO stays 0.
- divu 100/7: stall_req high 33 cycles, div_done in cycle 33, LO=14, HI=2. An unsigned operand 0xFFFFFFFF/2 gives LO=0x7FFFFFFF, HI=1.
- div −7/2 (0xFFFFFFF9/2): LO=0xFFFFFFFD, HI=0xFFFFFFFF. Also 7/−2 gives LO=−3, HI=1, and 0x80000000/0xFFFFFFFF gives LO=0x80000000, HI=0.
- div 5/0: done and div_by_zero in cycle 1, LO=0xFFFFFFFF, HI=5.
- Annul at cycle 10 of a division: idle next cycle, stall_req=0, HI/LO unchanged, no done pulse. A new div_start is then accepted normally.
- wb_we_lo=1 with wb_lo=0xAAAA in the DONE cycle of 9/3: LO=3 wins and lo_rd=3 that cycle.
- Separately, a wb write to HI during BUSY is committed immediately.
- rst asserted at cycle 20 of a division: state=IDLE, HI=LO=0, no done pulse.

Source files
------------

// File: rtl/hilo_if.sv
// rtl/hilo_if.sv - HI/LO unit bus: write-backs, divide command, stall and forwarded HI/LO
// Ports (slave = hilo_unit, master = pipeline):
//   wb_we_hi/wb_we_lo/wb_hi/wb_lo  write-back of HI/LO
//   div_start/div_signed/div_a/div_b/div_annul  divide command and cancel
//   stall_req/div_busy/div_done/div_by_zero     status toward the pipeline
//   hi_rd/lo_rd                                 forwarded HI/LO toward the ALU
interface hilo_if #(parameter int WIDTH = 32);
    logic             wb_we_hi;
    logic             wb_we_lo;
    logic [WIDTH-1:0] wb_hi;
    logic [WIDTH-1:0] wb_lo;
    logic             div_start;
    logic             div_signed;
    logic [WIDTH-1:0] div_a;
    logic [WIDTH-1:0] div_b;
    logic             div_annul;
    logic             stall_req;
    logic             div_busy;
    logic             div_done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi_rd;
    logic [WIDTH-1:0] lo_rd;

    modport master (
        output wb_we_hi, wb_we_lo, wb_hi, wb_lo,
        output div_start, div_signed, div_a, div_b, div_annul,
        input  stall_req, div_busy, div_done, div_by_zero, hi_rd, lo_rd
    );

    modport slave (
        input  wb_we_hi, wb_we_lo, wb_hi, wb_lo,
        input  div_start, div_signed, div_a, div_b, div_annul,
        output stall_req, div_busy, div_done, div_by_zero, hi_rd, lo_rd
    );
endinterface

// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - HI/LO register pair with background restoring divider and forwarding
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   hilo_if.slave: write-backs, divide command, stall/status, forwarded hi_rd/lo_rd
module hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic   clk,
    input  logic   rst,
    hilo_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvsr;
    logic             sign_q;
    logic             sign_r;
    logic             dz;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] res_lo;
    logic [WIDTH-1:0] res_hi;
    logic             commit;

    always_comb begin
        abs_a  = (bus.div_signed && bus.div_a[WIDTH-1]) ? -bus.div_a : bus.div_a;
        abs_b  = (bus.div_signed && bus.div_b[WIDTH-1]) ? -bus.div_b : bus.div_b;
        // rem < dvsr always holds, so a set MSB of the (WIDTH+1)-bit
        // difference means the trial subtraction went negative.
        rem_sh = {rem, quo[WIDTH-1]};
        trial  = rem_sh - {1'b0, dvsr};
        res_lo = sign_q ? -quo : quo;
        res_hi = sign_r ? -rem : rem;
        commit = (state == DONE) && !bus.div_annul;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            hi_reg <= '0;
            lo_reg <= '0;
            rem    <= '0;
            quo    <= '0;
            dvsr   <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            dz     <= 1'b0;
            cnt    <= '0;
        end else begin
            // Divider result outranks a same-edge write-back on both halves.
            if (commit) begin
                hi_reg <= res_hi;
                lo_reg <= res_lo;
            end else begin
                if (bus.wb_we_hi) hi_reg <= bus.wb_hi;
                if (bus.wb_we_lo) lo_reg <= bus.wb_lo;
            end

            case (state)
                IDLE: begin
                    if (bus.div_start) begin
                        if (bus.div_b == '0) begin
                            // Divide by zero: quotient all ones, remainder = dividend.
                            quo    <= '1;
                            rem    <= bus.div_a;
                            sign_q <= 1'b0;
                            sign_r <= 1'b0;
                            dz     <= 1'b1;
                            state  <= DONE;
                        end else begin
                            sign_q <= bus.div_signed & (bus.div_a[WIDTH-1] ^ bus.div_b[WIDTH-1]);
                            sign_r <= bus.div_signed & bus.div_a[WIDTH-1];
                            quo    <= abs_a;
                            dvsr   <= abs_b;
                            rem    <= '0;
                            cnt    <= '0;
                            dz     <= 1'b0;
                            state  <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (bus.div_annul) begin
                        state <= IDLE;
                    end else begin
                        if (!trial[WIDTH]) begin
                            rem <= trial[WIDTH-1:0];
                            quo <= {quo[WIDTH-2:0], 1'b1};
                        end else begin
                            rem <= rem_sh[WIDTH-1:0];
                            quo <= {quo[WIDTH-2:0], 1'b0};
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH - 1)) state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.stall_req   = ((state == IDLE) && bus.div_start) || (state == BUSY);
    assign bus.div_busy    = (state == BUSY);
    assign bus.div_done    = commit;
    assign bus.div_by_zero = commit && dz;
    assign bus.hi_rd       = commit ? res_hi : (bus.wb_we_hi ? bus.wb_hi : hi_reg);
    assign bus.lo_rd       = commit ? res_lo : (bus.wb_we_lo ? bus.wb_lo : lo_reg);
endmodule

// File: tb/tb_hilo_unit.sv
// tb/tb_hilo_unit.sv - self-checking bench for hilo_unit: vector table, random divides, corner sequences
module tb_hilo_unit;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    hilo_if #(.WIDTH(32)) ifc ();
    hilo_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(ifc.slave));

    typedef struct {
        string       nm;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        int          lat;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer division; signed case in 64-bit so that
    // -2^31 / -1 wraps to 0x80000000 naturally.
    function automatic void ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] lo, output logic [31:0] hi);
        longint la, lb;
        if (b == 32'd0) begin
            lo = 32'hFFFF_FFFF;
            hi = a;
        end else if (sgn) begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
            lo = 32'(la / lb);
            hi = 32'(la % lb);
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endfunction

    task automatic do_div(input string nm, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] elo, input logic [31:0] ehi, input int elat);
        int stalls;
        int done_at;
        stalls  = 0;
        done_at = -1;
        tick();
        ifc.div_start  = 1'b1;
        ifc.div_signed = sgn;
        ifc.div_a      = a;
        ifc.div_b      = b;
        #1;
        if (ifc.stall_req) stalls++;
        for (int c = 1; c <= 100; c++) begin
            tick();
            ifc.div_start = 1'b0;
            #1;
            if (ifc.stall_req) stalls++;
            if (ifc.div_done) begin
                done_at = c;
                chk({nm, " div_by_zero"}, 32'(ifc.div_by_zero), 32'(b == 32'd0));
                chk({nm, " lo_fwd"}, ifc.lo_rd, elo);
                chk({nm, " hi_fwd"}, ifc.hi_rd, ehi);
                break;
            end
        end
        chk({nm, " done_cycle"}, 32'(done_at), 32'(elat));
        chk({nm, " stall_cycles"}, 32'(stalls), 32'(elat));
        tick();
        #1;
        chk({nm, " lo_reg"}, ifc.lo_rd, elo);
        chk({nm, " hi_reg"}, ifc.hi_rd, ehi);
        chk({nm, " idle"}, 32'({ifc.div_busy, ifc.stall_req, ifc.div_done}), 32'd0);
    endtask

    initial begin
        logic [31:0] rlo, rhi, ra, rb;
        logic        rs;
        int          seen;

        vecs[0] = '{"divu_100_7",   1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         33};
        vecs[1] = '{"divu_max_2",   1'b0, 32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF, 32'd1,         33};
        vecs[2] = '{"div_m7_2",     1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 33};
        vecs[3] = '{"div_7_m2",     1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         33};
        vecs[4] = '{"div_min_m1",   1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         33};
        vecs[5] = '{"div_5_0",      1'b1, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         1};
        vecs[6] = '{"divu_9_3",     1'b0, 32'd9,         32'd3,         32'd3,         32'd0,         33};

        rst = 1'b1;
        ifc.wb_we_hi = 1'b0; ifc.wb_we_lo = 1'b0; ifc.wb_hi = '0; ifc.wb_lo = '0;
        ifc.div_start = 1'b0; ifc.div_signed = 1'b0; ifc.div_a = '0; ifc.div_b = '0;
        ifc.div_annul = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset hi_rd", ifc.hi_rd, 32'd0);
        chk("reset lo_rd", ifc.lo_rd, 32'd0);
        chk("reset status", 32'({ifc.stall_req, ifc.div_busy, ifc.div_done, ifc.div_by_zero}), 32'd0);

        // Write-back forwarding, then registered value.
        ifc.wb_we_hi = 1'b1; ifc.wb_hi = 32'h1234_5678;
        #1;
        chk("wb hi forward", ifc.hi_rd, 32'h1234_5678);
        tick();
        ifc.wb_we_hi = 1'b0;
        #1;
        chk("wb hi reg", ifc.hi_rd, 32'h1234_5678);
        chk("wb lo untouched", ifc.lo_rd, 32'd0);

        for (int i = 0; i < 7; i++)
            do_div(vecs[i].nm, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi, vecs[i].lat);

        for (int i = 0; i < 20; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 1) rb = 32'($urandom_range(1, 15));
            if (i % 4 == 2) rb = rb >> $urandom_range(8, 28);
            if (i % 7 == 3) rb = 32'd0;
            if (rb == 32'd0 && i % 7 != 3) rb = 32'd1;
            ref_div(rs, ra, rb, rlo, rhi);
            do_div($sformatf("rand%0d", i), rs, ra, rb, rlo, rhi, (rb == 32'd0) ? 1 : 33);
        end

        // Annul mid-division: HI/LO keep preloaded values, no done pulse.
        tick();
        ifc.wb_we_hi = 1'b1; ifc.wb_hi = 32'h1111_1111;
        ifc.wb_we_lo = 1'b1; ifc.wb_lo = 32'h2222_2222;
        tick();
        ifc.wb_we_hi = 1'b0; ifc.wb_we_lo = 1'b0;
        ifc.div_start = 1'b1; ifc.div_signed = 1'b0; ifc.div_a = 32'd1000; ifc.div_b = 32'd3;
        for (int c = 1; c < 10; c++) begin
            tick();
            ifc.div_start = 1'b0;
        end
        tick();
        ifc.div_annul = 1'b1;
        #1;
        chk("annul busy before", 32'(ifc.div_busy), 32'd1);
        tick();
        ifc.div_annul = 1'b0;
        #1;
        chk("annul idle", 32'({ifc.div_busy, ifc.stall_req}), 32'd0);
        chk("annul hi kept", ifc.hi_rd, 32'h1111_1111);
        chk("annul lo kept", ifc.lo_rd, 32'h2222_2222);
        seen = 0;
        repeat (40) begin
            tick();
            if (ifc.div_done) seen = 1;
        end
        chk("annul no done", 32'(seen), 32'd0);
        chk("annul lo still", ifc.lo_rd, 32'h2222_2222);
        do_div("after_annul", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 33);

        // Write-back of LO in the DONE cycle loses to the divider result.
        tick();
        ifc.div_start = 1'b1; ifc.div_signed = 1'b0; ifc.div_a = 32'd9; ifc.div_b = 32'd3;
        seen = 0;
        for (int c = 1; c <= 100; c++) begin
            tick();
            ifc.div_start = 1'b0;
            if (ifc.div_done) begin
                ifc.wb_we_lo = 1'b1; ifc.wb_lo = 32'h0000_AAAA;
                #1;
                chk("done vs wb lo_rd", ifc.lo_rd, 32'd3);
                seen = 1;
                break;
            end
        end
        chk("done vs wb seen", 32'(seen), 32'd1);
        tick();
        ifc.wb_we_lo = 1'b0;
        #1;
        chk("done vs wb lo_reg", ifc.lo_rd, 32'd3);

        // HI write-back during BUSY commits at once; start while busy is ignored.
        tick();
        ifc.div_start = 1'b1; ifc.div_signed = 1'b0; ifc.div_a = 32'd100; ifc.div_b = 32'd7;
        for (int c = 1; c < 5; c++) begin
            tick();
            ifc.div_start = 1'b0;
        end
        tick();
        ifc.wb_we_hi = 1'b1; ifc.wb_hi = 32'hCAFE_BABE;
        ifc.div_start = 1'b1; ifc.div_a = 32'd55; ifc.div_b = 32'd5;
        #1;
        chk("busy wb hi fwd", ifc.hi_rd, 32'hCAFE_BABE);
        tick();
        ifc.wb_we_hi = 1'b0;
        #1;
        chk("busy wb hi reg", ifc.hi_rd, 32'hCAFE_BABE);
        chk("busy still", 32'(ifc.div_busy), 32'd1);
        seen = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (ifc.div_done) begin
                ifc.div_start = 1'b0;
                #1;
                chk("busy start ignored lo", ifc.lo_rd, 32'd14);
                chk("busy start ignored hi", ifc.hi_rd, 32'd2);
                seen = 1;
                break;
            end
        end
        ifc.div_start = 1'b0;
        chk("busy done seen", 32'(seen), 32'd1);
        tick();
        #1;
        chk("busy then idle", 32'(ifc.div_busy), 32'd0);

        // Reset at cycle 20 aborts the division and clears HI/LO.
        tick();
        ifc.div_start = 1'b1; ifc.div_signed = 1'b1; ifc.div_a = 32'd77; ifc.div_b = 32'd4;
        for (int c = 1; c < 20; c++) begin
            tick();
            ifc.div_start = 1'b0;
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst mid idle", 32'({ifc.div_busy, ifc.stall_req, ifc.div_done}), 32'd0);
        chk("rst mid hi", ifc.hi_rd, 32'd0);
        chk("rst mid lo", ifc.lo_rd, 32'd0);
        seen = 0;
        repeat (40) begin
            tick();
            if (ifc.div_done) seen = 1;
        end
        chk("rst mid no done", 32'(seen), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
